// File: rtl/mac_operand_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mac_feed_pkg
// Description : Shared state encoding and helpers for the MAC operand feeder.
// Revision    : 1.0 - initial release
// ============================================================================
package mac_feed_pkg;

    localparam int DATA_W_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } feed_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_operand_feeder_if.sv
`default_nettype none
// ============================================================================
// Module      : mac_operand_feeder_if
// Description : Host write / MAC drive bundle for the operand feeder.
// Revision    : 1.0 - initial release
// ============================================================================
interface mac_operand_feeder_if #(
    parameter int DATA_W = 8
);
    logic              a_wr;
    logic [DATA_W-1:0] a_data;
    logic              b_wr;
    logic [DATA_W-1:0] b_data;
    logic              start;
    logic              a_full;
    logic              b_full;
    logic              busy;
    logic              done;
    logic              Clr;
    logic              En;
    logic [DATA_W-1:0] Ain;
    logic [DATA_W-1:0] Bin;

    // master = host side, slave = feeder side
    modport master (
        output a_wr, a_data, b_wr, b_data, start,
        input  a_full, b_full, busy, done, Clr, En, Ain, Bin
    );

    modport slave (
        input  a_wr, a_data, b_wr, b_data, start,
        output a_full, b_full, busy, done, Clr, En, Ain, Bin
    );
endinterface
`default_nettype wire

// File: rtl/mac_operand_feeder_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock first-word-fall-through FIFO; drops writes when full.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              wr,
    input  wire logic              rd,
    input  wire logic [DATA_W-1:0] din,
    output logic      [DATA_W-1:0] dout,
    output logic                   full,
    output logic                   empty
);

    localparam int c_AW = $clog2(DEPTH);
    localparam logic [c_AW:0] c_PTR_ONE = {{c_AW{1'b0}}, 1'b1};

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [c_AW:0]     r_wr_ptr;
    logic [c_AW:0]     r_rd_ptr;
    logic              w_push;
    logic              w_pop;

    assign w_push = wr && !full;
    assign w_pop  = rd && !empty;

    // Extra pointer MSB separates the full case from the empty case
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign dout  = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[c_AW-1:0]] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/mac_operand_feeder.sv
`default_nettype none
// ============================================================================
// Module      : mac_operand_feeder
// Description : Buffers two operand vectors and replays them into the MAC as
//               clear / enable burst / drain / done framed runs.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_operand_feeder
    import mac_feed_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter int DRAIN_CYC = 3
) (
    input  wire logic             clk,
    input  wire logic             rst,
    mac_operand_feeder_if.slave   bus
);

    localparam int c_CNT_W = max_int($clog2(DEPTH) + 1, $clog2(DRAIN_CYC + 1));
    localparam logic [c_CNT_W-1:0] c_RUN_LAST   = c_CNT_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_DRAIN_LAST = c_CNT_W'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

    feed_state_t       r_state;
    feed_state_t       w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;

    logic              r_clr;
    logic              r_en;
    logic              r_done;
    logic              r_busy;
    logic [DATA_W-1:0] r_ain;
    logic [DATA_W-1:0] r_bin;

    logic              w_a_full;
    logic              w_b_full;
    logic              w_a_empty;
    logic              w_b_empty;
    logic [DATA_W-1:0] w_a_dout;
    logic [DATA_W-1:0] w_b_dout;
    logic              w_wr_ok;
    logic              w_pop;

    assign w_wr_ok = (r_state == IDLE);
    // Pop on every edge entering a RUN cycle so the registered pair lines up with En
    assign w_pop   = (w_state_nxt == RUN);

    sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo_a (
        .clk   (clk),
        .rst   (rst),
        .wr    (bus.a_wr && w_wr_ok),
        .rd    (w_pop),
        .din   (bus.a_data),
        .dout  (w_a_dout),
        .full  (w_a_full),
        .empty (w_a_empty)
    );

    sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo_b (
        .clk   (clk),
        .rst   (rst),
        .wr    (bus.b_wr && w_wr_ok),
        .rd    (w_pop),
        .din   (bus.b_data),
        .dout  (w_b_dout),
        .full  (w_b_full),
        .empty (w_b_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (bus.start && w_a_full && w_b_full) w_state_nxt = CLEAR;
            CLEAR: w_state_nxt = RUN;
            RUN:   if (r_cnt == c_RUN_LAST) w_state_nxt = (DRAIN_CYC == 0) ? DONE : DRAIN;
            DRAIN: if (r_cnt == c_DRAIN_LAST) w_state_nxt = DONE;
            DONE:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_clr   <= 1'b0;
            r_en    <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_ain   <= '0;
            r_bin   <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Counter restarts on every state change and only runs in RUN/DRAIN
            if ((w_state_nxt == r_state) && (r_state == RUN || r_state == DRAIN))
                r_cnt <= r_cnt + c_CNT_ONE;
            else
                r_cnt <= '0;
            r_clr  <= (w_state_nxt == CLEAR);
            r_en   <= (w_state_nxt == RUN);
            r_done <= (w_state_nxt == DONE);
            r_busy <= (w_state_nxt != IDLE);
            r_ain  <= (w_state_nxt == RUN) ? w_a_dout : '0;
            r_bin  <= (w_state_nxt == RUN) ? w_b_dout : '0;
        end
    end

    assign bus.a_full = w_a_full;
    assign bus.b_full = w_b_full;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.Clr    = r_clr;
    assign bus.En     = r_en;
    assign bus.Ain    = r_ain;
    assign bus.Bin    = r_bin;

endmodule
`default_nettype wire
